alu_iter: RTL and testbench

- Parametrised, handshaked execution unit succeeding the single-cycle combinational ALU in the cpu core.
- Registers every result and adds unsigned compares and corrected shift/compare semantics.
- Adds an iterative multiply/divide engine with RISC-V M-extension semantics.
- Sits between decode/regfile operand select and writeback; a tag rides along with each operation.

---
 rtl/alu_iter.sv | 199 +++++++++++++++++++
 tb/tb_alu_iter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: handshaked, fully registered ALU with a tag passthrough.
// Define ALU_MULDIV_EN to add the iterative RISC-V M-extension multiply/divide engine.
module alu_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int SH_W = $clog2(XLEN);

    logic            busy;
    logic            accept;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] sc_res;
    logic            sc_illegal;
    logic            sc_iter;

    assign in_ready = !rst && !flush && !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = in_b[SH_W-1:0];

`ifdef ALU_MULDIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t              state;
    logic [SH_W-1:0]     cnt;
    logic                op_hi;
    logic                is_rem;
    logic                neg_res;
    logic [TAG_W-1:0]    tag_q;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     divisor;
    logic                sign_op;
    logic                last;
    logic [2*XLEN-1:0]   prod_nxt;
    logic [2*XLEN-1:0]   mul_fin;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       trial;
    logic [XLEN-1:0]     rem_nxt;
    logic [XLEN-1:0]     quot_nxt;
    logic [XLEN-1:0]     div_val;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     div_res;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    assign busy    = (state != S_IDLE);
    assign sign_op = (in_op == 5'd17) || (in_op == 5'd20) || (in_op == 5'd22);
    assign last    = (cnt == SH_W'(XLEN-1));

    // One shift-add step and one restoring-division step per cycle; the final
    // step's result is folded straight into the output register.
    always_comb begin
        prod_nxt  = mplier[0] ? prod + mcand : prod;
        mul_fin   = neg_res ? -prod_nxt : prod_nxt;
        mul_res   = op_hi ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
        div_shift = {rem_q, quot[XLEN-1]};
        trial     = div_shift - {1'b0, divisor};
        rem_nxt   = trial[XLEN] ? div_shift[XLEN-1:0] : trial[XLEN-1:0];
        quot_nxt  = {quot[XLEN-2:0], ~trial[XLEN]};
        div_val   = is_rem ? rem_nxt : quot_nxt;
        div_res   = neg_res ? -div_val : div_val;
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        sc_res     = '0;
        sc_illegal = 1'b0;
        sc_iter    = 1'b0;
        case (in_op)
            5'd0:  sc_res = in_a + in_b;
            5'd1:  sc_res = in_a - in_b;
            5'd2:  sc_res = in_a & in_b;
            5'd3:  sc_res = in_a | in_b;
            5'd4:  sc_res = in_a ^ in_b;
            5'd5:  sc_res = in_a << shamt;
            5'd6:  sc_res = in_a >> shamt;
            5'd7:  sc_res = $signed(in_a) >>> shamt;
            5'd8:  sc_res = XLEN'(in_a == in_b);
            5'd9:  sc_res = XLEN'(in_a != in_b);
            5'd10: sc_res = XLEN'($signed(in_a) < $signed(in_b));
            5'd11: sc_res = XLEN'($signed(in_a) >= $signed(in_b));
            5'd12: sc_res = XLEN'(in_a < in_b);
            5'd13: sc_res = XLEN'(in_a >= in_b);
`ifdef ALU_MULDIV_EN
            5'd16, 5'd17, 5'd18: sc_iter = 1'b1;
            // in_op[1] selects remainder, in_op[0] selects unsigned
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (in_b == '0)
                    sc_res = in_op[1] ? in_a : '1;
                else if (!in_op[0] && in_a == MOST_NEG && in_b == '1)
                    sc_res = in_op[1] ? '0 : in_a;
                else
                    sc_iter = 1'b1;
            end
`endif
            default: sc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
            state       <= S_IDLE;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
`ifdef ALU_MULDIV_EN
            state     <= S_IDLE;
`endif
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (accept && !sc_iter) begin
                out_valid   <= 1'b1;
                out_data    <= sc_res;
                out_tag     <= in_tag;
                out_illegal <= sc_illegal;
            end
`ifdef ALU_MULDIV_EN
            case (state)
                S_IDLE: begin
                    if (accept && sc_iter) begin
                        mcand   <= {{XLEN{1'b0}}, mag(in_a, sign_op)};
                        mplier  <= mag(in_b, sign_op);
                        prod    <= '0;
                        rem_q   <= '0;
                        quot    <= mag(in_a, sign_op);
                        divisor <= mag(in_b, sign_op);
                        cnt     <= '0;
                        tag_q   <= in_tag;
                        op_hi   <= (in_op != 5'd16);
                        is_rem  <= in_op[1];
                        if (in_op[2])
                            neg_res <= sign_op && (in_op[1] ? in_a[XLEN-1]
                                                            : (in_a[XLEN-1] ^ in_b[XLEN-1]));
                        else
                            neg_res <= sign_op && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                        state   <= in_op[2] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        out_valid   <= 1'b1;
                        out_data    <= mul_res;
                        out_tag     <= tag_q;
                        out_illegal <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    quot  <= quot_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out_valid   <= 1'b1;
                        out_data    <= div_res;
                        out_tag     <= tag_q;
                        out_illegal <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed scenarios plus randomized ops checked
// against an arithmetic reference model; honours ALU_MULDIV_EN like the design.
module tb_alu_iter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_op = '0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    alu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_off = 1'b0;
    bit   rnd_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: results straight from the op definitions using 64-bit arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t        e;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        e.tag = tag;
        e.ill = 1'b0;
        e.lat = 1;
        e.d   = '0;
        case (op)
            5'd0:  e.d = a + b;
            5'd1:  e.d = a - b;
            5'd2:  e.d = a & b;
            5'd3:  e.d = a | b;
            5'd4:  e.d = a ^ b;
            5'd5:  e.d = a << b[4:0];
            5'd6:  e.d = a >> b[4:0];
            5'd7:  e.d = 32'(sa >>> b[4:0]);
            5'd8:  e.d = {31'b0, a == b};
            5'd9:  e.d = {31'b0, a != b};
            5'd10: e.d = {31'b0, sa < sb};
            5'd11: e.d = {31'b0, sa >= sb};
            5'd12: e.d = {31'b0, ua < ub};
            5'd13: e.d = {31'b0, ua >= ub};
`ifdef ALU_MULDIV_EN
            5'd16: begin p = ua * ub; e.d = p[31:0];  e.lat = 33; end
            5'd17: begin p = sa * sb; e.d = p[63:32]; e.lat = 33; end
            5'd18: begin p = ua * ub; e.d = p[63:32]; e.lat = 33; end
            5'd20, 5'd22: begin
                if (b == 0) e.d = (op == 5'd20) ? 32'hFFFF_FFFF : a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.d = (op == 5'd20) ? a : 32'd0;
                else begin
                    e.d = (op == 5'd20) ? 32'(sa / sb) : 32'(sa % sb);
                    e.lat = 33;
                end
            end
            5'd21, 5'd23: begin
                if (b == 0) e.d = (op == 5'd21) ? 32'hFFFF_FFFF : a;
                else begin
                    e.d = (op == 5'd21) ? 32'(ua / ub) : 32'(ua % ub);
                    e.lat = 33;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit push, output int waits);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        n = 0;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        waits = n;
        if (n >= 300) begin
            chk("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        if (push) begin
            e = model(op, a, b, tag);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    // Monitor: latency on first appearance, contents on each transfer.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !mon_off && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat - 1));
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        chk("data", out_data, q[0].d);
                        chk("tag", {27'b0, out_tag}, {27'b0, q[0].tag});
                        chk("illegal", {31'b0, out_illegal}, {31'b0, q[0].ill});
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   w;
        bit   anyv;
        logic [31:0] ops_a [5];
        logic [31:0] ops_b [5];
        logic [4:0]  ops_op[5];

        // Reset
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Back-to-back single-cycle ops
        out_ready = 1'b1;
        issue(5'd1, 32'd5, 32'd7, 5'd1, 1'b1, w);
        issue(5'd7, 32'h8000_0000, 32'd33, 5'd2, 1'b1, w);
        issue(5'd12, 32'd1, 32'hFFFF_FFFF, 5'd3, 1'b1, w);
        repeat (2) @(negedge clk);

        // Backpressure
        out_ready = 1'b0;
        issue(5'd0, 32'd1, 32'd2, 5'd4, 1'b1, w);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", out_data, 32'd3);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 1'b1, w);
        chk("accept_on_ready", 32'(w), 32'd0);

        // Iterative and special-case mul/div ops, plus illegal codes
        ops_op = '{5'd17, 5'd20, 5'd22, 5'd21, 5'd20};
        ops_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd10, 32'h8000_0000};
        ops_b  = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++)
            issue(ops_op[i], ops_a[i], ops_b[i], 5'(6 + i), 1'b1, w);
        issue(5'd31, 32'd3, 32'd4, 5'd11, 1'b1, w);
        issue(5'd16, 32'd3, 32'd4, 5'd12, 1'b1, w);
        issue(5'd19, 32'd3, 32'd4, 5'd13, 1'b1, w);
        repeat (40) @(negedge clk);

        // Kill a divide mid-flight, first with flush and then with reset
        for (int k = 0; k < 2; k++) begin
            mon_off = 1'b1;
            out_ready = 1'b0;
            issue(5'd21, 32'd100, 32'd3, 5'd20, 1'b0, w);
            repeat (9) @(negedge clk);
            if (k == 0) flush = 1'b1; else rst = 1'b1;
            #1;
            chk("kill_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
            rst = 1'b0;
            #1;
            chk("kill_out_valid", {31'b0, out_valid}, 32'd0);
            if (k == 1) begin
                chk("rst_clears_data", out_data, 32'd0);
                chk("rst_clears_tag", {27'b0, out_tag}, 32'd0);
            end
            mon_off = 1'b0;
            out_ready = 1'b1;
            issue(5'd0, 32'd40, 32'd2, 5'(21 + k), 1'b1, w);
            chk("post_kill_accept", 32'(w), 32'd0);
            anyv = 1'b0;
            repeat (40) begin
                @(negedge clk);
                #1;
                if (out_valid && out_tag == 5'd20) anyv = 1'b1;
            end
            chk("killed_never_valid", {31'b0, anyv}, 32'd0);
            @(negedge clk);
        end

        // Randomized ops with random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            issue(5'($urandom_range(0, 31)), rnd_operand(), rnd_operand(),
                  5'($urandom), 1'b1, w);
        end
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
